// File: rtl/full_adder_test_top.sv
// Quiz harness: a golden and a gate-level 1-bit full adder side by side, with a clocked scoreboard.
// Optional macro FA_TEST_FAULT_INJECT_EN lets fault_inj invert the test sum to exercise the checker.
module full_adder_test_top #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  input  logic             fault_inj,
  output logic             out_true,
  output logic             cout_true,
  output logic             out_test,
  output logic             cout_test,
  output logic             match,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             fail,
  output logic [2:0]       first_err_vec
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic s1;

  // Golden model: plain 2-bit arithmetic sum.
  assign {cout_true, out_true} = {1'b0, a} + {1'b0, b} + {1'b0, cin};

  assign s1        = a ^ b;
  assign cout_test = (a & b) | (s1 & cin);

`ifdef FA_TEST_FAULT_INJECT_EN
  assign out_test = s1 ^ cin ^ fault_inj;
`else
  logic unused_fault_inj;
  assign unused_fault_inj = fault_inj;
  assign out_test         = s1 ^ cin;
`endif

  assign match = (out_test == out_true) && (cout_test == cout_true);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_count     <= '0;
      err_count     <= '0;
      fail          <= 1'b0;
      first_err_vec <= 3'b000;
    end else begin
      if (vec_count != CNT_MAX) vec_count <= vec_count + CNT_W'(1);
      if (!match) begin
        if (err_count != CNT_MAX) err_count <= err_count + CNT_W'(1);
        // Only the first mismatch is captured; later ones leave the record alone.
        if (!fail) begin
          fail          <= 1'b1;
          first_err_vec <= {a, b, cin};
        end
      end
    end
  end

endmodule

// File: tb/tb_full_adder_test_top.sv
// Scoreboard bench: driver pushes model expectations into a queue, a monitor pops and compares after each edge.
// Runs a 16-bit-counter instance and a 4-bit-counter instance from the same stimulus.
module tb_full_adder_test_top;

`ifdef FA_TEST_FAULT_INJECT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0, b = 1'b0, cin = 1'b0, fault_inj = 1'b0;

  logic        out_true_w, cout_true_w, out_test_w, cout_test_w, match_w, fail_w;
  logic [15:0] vec_count_w, err_count_w;
  logic [2:0]  first_err_vec_w;
  logic        out_true_n, cout_true_n, out_test_n, cout_test_n, match_n, fail_n;
  logic [3:0]  vec_count_n, err_count_n;
  logic [2:0]  first_err_vec_n;

  full_adder_test_top #(.CNT_W(16)) dut_wide (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .fault_inj(fault_inj),
    .out_true(out_true_w), .cout_true(cout_true_w), .out_test(out_test_w),
    .cout_test(cout_test_w), .match(match_w), .vec_count(vec_count_w),
    .err_count(err_count_w), .fail(fail_w), .first_err_vec(first_err_vec_w)
  );

  full_adder_test_top #(.CNT_W(4)) dut_narrow (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .fault_inj(fault_inj),
    .out_true(out_true_n), .cout_true(cout_true_n), .out_test(out_test_n),
    .cout_test(cout_test_n), .match(match_n), .vec_count(vec_count_n),
    .err_count(err_count_n), .fail(fail_n), .first_err_vec(first_err_vec_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    int out_t, cout_t, out_x, cout_x, mat;
    int vec, err, fl, first;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_vec = 0, m_err = 0, m_fail = 0, m_first = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  // Drive one cycle of stimulus and record what the harness should report after the next edge.
  task automatic apply(input bit r, input bit va, input bit vb, input bit vc, input bit f);
    exp_t e;
    int   total;
    @(negedge clk);
    rst = r; a = va; b = vb; cin = vc; fault_inj = f;
    total    = int'(va) + int'(vb) + int'(vc);
    e.out_t  = total % 2;
    e.cout_t = total / 2;
    e.out_x  = (total % 2) ^ int'(FAULT_EN && f);
    e.cout_x = total / 2;
    e.mat    = (e.out_x == e.out_t) ? 1 : 0;
    if (r) begin
      m_vec = 0; m_err = 0; m_fail = 0; m_first = 0;
    end else begin
      m_vec++;
      if (e.mat == 0) begin
        m_err++;
        if (m_fail == 0) begin
          m_fail  = 1;
          m_first = int'(va) * 4 + int'(vb) * 2 + int'(vc);
        end
      end
    end
    e.vec = m_vec; e.err = m_err; e.fl = m_fail; e.first = m_first;
    q.push_back(e);
  endtask

  task automatic apply_random(input int n, input bit f);
    for (int i = 0; i < n; i++)
      apply(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), f);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("out_true",        int'(out_true_w),      e.out_t);
        check("cout_true",       int'(cout_true_w),     e.cout_t);
        check("out_test",        int'(out_test_w),      e.out_x);
        check("cout_test",       int'(cout_test_w),     e.cout_x);
        check("match",           int'(match_w),         e.mat);
        check("vec_count",       int'(vec_count_w),     sat(e.vec, 16));
        check("err_count",       int'(err_count_w),     sat(e.err, 16));
        check("fail",            int'(fail_w),          e.fl);
        check("first_err_vec",   int'(first_err_vec_w), e.first);
        check("vec_count_w4",    int'(vec_count_n),     sat(e.vec, 4));
        check("err_count_w4",    int'(err_count_n),     sat(e.err, 4));
        check("fail_w4",         int'(fail_n),          e.fl);
        check("first_err_vec_w4", int'(first_err_vec_n), e.first);
      end
    end
  end

  initial begin : driver
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Exhaustive sweep of the truth table.
    for (int v = 0; v < 8; v++) begin
      bit [2:0] bits;
      bits = 3'(v);
      apply(1'b0, bits[2], bits[1], bits[0], 1'b0);
    end

    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_random(100, 1'b0);
    @(posedge clk);
    #2;
    check("vec_count_after_100", int'(vec_count_w), 100);
    check("err_count_after_100", int'(err_count_w), 0);

    // Directed faults: first on {1,0,0}, later one on {0,1,1}.
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    apply_random(3, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    apply_random(20, 1'b1);

    // One-edge reset mid-run after errors, then resume counting.
    apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    apply_random(6, 1'b0);
    apply_random(20, 1'b1);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
